// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU
// MEM-stage path (port C) and the debug/loader path (port D).
module dm_arbiter #(
  parameter int AW = 10,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  output logic [DW-1:0] c_rdata,
  output logic          c_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  input  logic          d_lock,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_din,
  output logic          dm_we,
  input  logic [DW-1:0] dm_dout,
  output logic [CW-1:0] c_cnt,
  output logic [CW-1:0] d_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    GNT_C,
    GNT_D,
    ACK_C,
    ACK_D
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          last_d;
  logic          ec;
  logic          ed;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] din_q;

  // A port sitting in its own ACK cycle is ignored so a held req is not re-issued.
  assign ec = c_req & ~d_lock & (state != ACK_C);
  assign ed = d_req & (state != ACK_D);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      GNT_C: state_nxt = ACK_C;
      GNT_D: state_nxt = ACK_D;
      default: begin
        if (ec && (!ed || last_d)) begin
          state_nxt = GNT_C;
        end else if (ed) begin
          state_nxt = GNT_D;
        end else begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  assign c_ack   = (state == ACK_C);
  assign d_ack   = (state == ACK_D);
  assign c_stall = c_req & ~c_ack;

  // Memory bus follows the granted port; outside a grant it parks on the last access.
  always_comb begin
    dm_addr = addr_q;
    dm_din  = din_q;
    dm_we   = 1'b0;
    case (state)
      GNT_C: begin
        dm_addr = c_addr;
        dm_din  = c_wdata;
        dm_we   = c_we;
      end
      GNT_D: begin
        dm_addr = d_addr;
        dm_din  = d_wdata;
        dm_we   = d_we;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_d  <= 1'b1;
      addr_q  <= '0;
      din_q   <= '0;
      c_rdata <= '0;
      d_rdata <= '0;
      c_cnt   <= '0;
      d_cnt   <= '0;
    end else begin
      case (state)
        GNT_C: begin
          last_d <= 1'b0;
          addr_q <= c_addr;
          din_q  <= c_wdata;
          if (!c_we) begin
            c_rdata <= dm_dout;
          end
        end
        GNT_D: begin
          last_d <= 1'b1;
          addr_q <= d_addr;
          din_q  <= d_wdata;
          if (!d_we) begin
            d_rdata <= dm_dout;
          end
        end
        ACK_C: c_cnt <= c_cnt + CW'(1);
        ACK_D: d_cnt <= d_cnt + CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios plus a randomized
// two-requester phase checked against a transaction-level memory model.
module tb_dm_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk;
  logic          rst;
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_ack;
  logic [DW-1:0] c_rdata;
  logic          c_stall;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          d_lock;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_din;
  logic          dm_we;
  logic [DW-1:0] dm_dout;
  logic [CW-1:0] c_cnt;
  logic [CW-1:0] d_cnt;

  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];

  int tests_run;
  int tests_failed;
  int exp_c;
  int exp_d;

  dm_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .c_req   (c_req),
    .c_we    (c_we),
    .c_addr  (c_addr),
    .c_wdata (c_wdata),
    .c_ack   (c_ack),
    .c_rdata (c_rdata),
    .c_stall (c_stall),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_ack   (d_ack),
    .d_rdata (d_rdata),
    .d_lock  (d_lock),
    .dm_addr (dm_addr),
    .dm_din  (dm_din),
    .dm_we   (dm_we),
    .dm_dout (dm_dout),
    .c_cnt   (c_cnt),
    .d_cnt   (d_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for dm_1k: word-organised, combinational read, write on the rising edge.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i * 3);
  end
  always @(posedge clk) begin
    if (dm_we) mem[dm_addr[AW-1:2]] <= dm_din;
  end
  assign dm_dout = mem[dm_addr[AW-1:2]];

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit is_d, input bit we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata);
    if (is_d) begin
      d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    end else begin
      c_we = we; c_addr = addr; c_wdata = wdata; c_req = 1'b1;
    end
  endtask

  task automatic release_port(input bit is_d);
    if (is_d) d_req = 1'b0;
    else      c_req = 1'b0;
  endtask

  // Returns the number of negedges until the port's ack, or -1 if none within limit.
  task automatic wait_ack(input bit is_d, input int limit, output int cycles);
    cycles = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if ((is_d ? d_ack : c_ack) === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_c = 0;
    exp_d = 0;
  endtask

  bit            busy      [2];
  bit            cool      [2];
  bit            started   [2];
  bit            contended [2];
  int            wait_cyc  [2];
  bit            cur_we    [2];
  logic [AW-1:0] cur_addr  [2];
  logic [DW-1:0] cur_wdata [2];

  initial begin
    int            cyc_cnt;
    int            seen;
    bit            c_pend;
    bit            d_pend;
    logic          ack_p;
    logic [DW-1:0] rd_p;
    logic [AW-1:0] a;

    tests_run = 0; tests_failed = 0; exp_c = 0; exp_d = 0;
    rst = 1'b0; d_lock = 1'b0;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    // Reset values, then an idle stretch with no requests.
    @(negedge clk);
    checkOutput("rst_c_ack", 64'(c_ack), 64'(0));
    checkOutput("rst_d_ack", 64'(d_ack), 64'(0));
    checkOutput("rst_c_rdata", 64'(c_rdata), 64'(0));
    checkOutput("rst_d_rdata", 64'(d_rdata), 64'(0));
    checkOutput("rst_dm_we", 64'(dm_we), 64'(0));
    checkOutput("rst_dm_addr", 64'(dm_addr), 64'(0));
    checkOutput("rst_dm_din", 64'(dm_din), 64'(0));
    checkOutput("rst_c_cnt", 64'(c_cnt), 64'(0));
    checkOutput("rst_d_cnt", 64'(d_cnt), 64'(0));
    checkOutput("rst_c_stall", 64'(c_stall), 64'(0));
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("idle_dm_we", 64'(dm_we), 64'(0));
      checkOutput("idle_c_ack", 64'(c_ack), 64'(0));
    end

    // CPU store then load of the same word.
    applyStimulus(1'b0, 1'b1, 10'h010, 32'hDEADBEEF);
    @(negedge clk);
    checkOutput("st_dm_we", 64'(dm_we), 64'(1));
    checkOutput("st_dm_addr", 64'(dm_addr), 64'(10'h010));
    checkOutput("st_dm_din", 64'(dm_din), 64'(32'hDEADBEEF));
    checkOutput("st_early_ack", 64'(c_ack), 64'(0));
    @(negedge clk);
    checkOutput("st_ack", 64'(c_ack), 64'(1));
    checkOutput("st_stall_at_ack", 64'(c_stall), 64'(0));
    release_port(1'b0); exp_c++;
    @(negedge clk);
    checkOutput("st_ack_pulse", 64'(c_ack), 64'(0));
    checkOutput("st_c_cnt", 64'(c_cnt), 64'(exp_c));
    applyStimulus(1'b0, 1'b0, 10'h010, 32'h0);
    #1;
    checkOutput("ld_stall_1", 64'(c_stall), 64'(1));
    @(negedge clk);
    checkOutput("ld_stall_2", 64'(c_stall), 64'(1));
    checkOutput("ld_dm_we", 64'(dm_we), 64'(0));
    @(negedge clk);
    checkOutput("ld_ack", 64'(c_ack), 64'(1));
    checkOutput("ld_rdata", 64'(c_rdata), 64'(32'hDEADBEEF));
    checkOutput("ld_stall_end", 64'(c_stall), 64'(0));
    release_port(1'b0); exp_c++;
    @(negedge clk);
    checkOutput("ld_c_cnt", 64'(c_cnt), 64'(exp_c));

    // Simultaneous reads after reset: CPU first, then strict alternation every 2 cycles.
    do_reset();
    applyStimulus(1'b0, 1'b0, 10'h020, 32'h0);
    applyStimulus(1'b1, 1'b0, 10'h040, 32'h0);
    seen = 0; c_pend = 1'b0; d_pend = 1'b0;
    for (int cyc = 1; cyc <= 30 && seen < 10; cyc++) begin
      @(negedge clk);
      if (c_ack === 1'b1 || d_ack === 1'b1) begin
        checkOutput("alt_port_is_d", 64'(d_ack), 64'(seen % 2));
        checkOutput("alt_cycle", 64'(cyc), 64'(2 + 2 * seen));
        checkOutput("alt_single_ack", 64'(c_ack & d_ack), 64'(0));
        if (c_ack === 1'b1) begin
          checkOutput("alt_c_rdata", 64'(c_rdata), 64'(mem[8]));
          release_port(1'b0); exp_c++;
          c_pend = (seen + 2 < 10);
        end else begin
          checkOutput("alt_d_rdata", 64'(d_rdata), 64'(mem[16]));
          release_port(1'b1); exp_d++;
          d_pend = (seen + 2 < 10);
        end
        seen++;
      end else begin
        if (c_pend) begin c_req = 1'b1; c_pend = 1'b0; end
        if (d_pend) begin d_req = 1'b1; d_pend = 1'b0; end
      end
    end
    checkOutput("alt_ack_total", 64'(seen), 64'(10));
    @(negedge clk);
    @(negedge clk);
    checkOutput("alt_c_cnt", 64'(c_cnt), 64'(exp_c));
    checkOutput("alt_d_cnt", 64'(d_cnt), 64'(exp_d));

    // d_lock raised during GNT_C: current access completes, the next one waits.
    applyStimulus(1'b0, 1'b0, 10'h080, 32'h0);
    @(negedge clk);
    d_lock = 1'b1;
    @(negedge clk);
    checkOutput("lock_inflight_ack", 64'(c_ack), 64'(1));
    release_port(1'b0); exp_c++;
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 10'h084, 32'hCAFE0001);
    applyStimulus(1'b1, 1'b0, 10'h0C0, 32'h0);
    wait_ack(1'b1, 6, cyc_cnt);
    checkOutput("lock_d_latency", 64'(cyc_cnt), 64'(2));
    checkOutput("lock_d_rdata", 64'(d_rdata), 64'(mem[48]));
    checkOutput("lock_c_blocked", 64'(c_ack), 64'(0));
    release_port(1'b1); exp_d++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("lock_c_stall", 64'(c_stall), 64'(1));
      checkOutput("lock_c_no_ack", 64'(c_ack), 64'(0));
    end
    d_lock = 1'b0;
    wait_ack(1'b0, 6, cyc_cnt);
    checkOutput("unlock_c_latency", 64'(cyc_cnt), 64'(2));
    release_port(1'b0); exp_c++;
    @(negedge clk);
    checkOutput("lock_mem_write", 64'(mem[33]), 64'(32'hCAFE0001));
    checkOutput("lock_c_cnt", 64'(c_cnt), 64'(exp_c));

    // D writes a word and C reads it back one cycle later.
    applyStimulus(1'b1, 1'b1, 10'h3FC, 32'h12345678);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 10'h3FC, 32'h0);
    wait_ack(1'b1, 6, cyc_cnt);
    checkOutput("coh_d_latency", 64'(cyc_cnt), 64'(1));
    release_port(1'b1); exp_d++;
    wait_ack(1'b0, 6, cyc_cnt);
    checkOutput("coh_c_latency", 64'(cyc_cnt), 64'(2));
    checkOutput("coh_c_rdata", 64'(c_rdata), 64'(32'h12345678));
    release_port(1'b0); exp_c++;
    @(negedge clk);

    // Randomized traffic: C owns words 0..127, D owns 128..255.
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    for (int p = 0; p < 2; p++) begin
      busy[p] = 1'b0; cool[p] = 1'b0; wait_cyc[p] = 0;
    end
    for (int cyc = 0; cyc < 412; cyc++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        ack_p = (p == 1) ? d_ack : c_ack;
        rd_p  = (p == 1) ? d_rdata : c_rdata;
        cool[p] = 1'b0;
        started[p] = 1'b0;
        if (busy[p]) begin
          wait_cyc[p]++;
          if (ack_p === 1'b1) begin
            if (contended[p])
              checkOutput(p == 1 ? "d_lat_shared" : "c_lat_shared",
                          64'(wait_cyc[p] >= 2 && wait_cyc[p] <= 4), 64'(1));
            else
              checkOutput(p == 1 ? "d_lat_free" : "c_lat_free", 64'(wait_cyc[p]), 64'(2));
            if (cur_we[p]) ref_mem[cur_addr[p][AW-1:2]] = cur_wdata[p];
            else checkOutput(p == 1 ? "d_rnd_rdata" : "c_rnd_rdata", 64'(rd_p),
                             64'(ref_mem[cur_addr[p][AW-1:2]]));
            if (p == 1) exp_d++;
            else        exp_c++;
            release_port(p == 1);
            busy[p] = 1'b0;
            cool[p] = 1'b1;
          end else if (wait_cyc[p] > 6) begin
            checkOutput(p == 1 ? "d_ack_timeout" : "c_ack_timeout", 64'(0), 64'(1));
            release_port(p == 1);
            busy[p] = 1'b0;
            cool[p] = 1'b1;
          end
        end else begin
          checkOutput(p == 1 ? "d_spurious_ack" : "c_spurious_ack", 64'(ack_p), 64'(0));
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (!busy[p] && !cool[p] && cyc < 400 && $urandom_range(0, 1) == 1) begin
          cur_we[p]    = ($urandom_range(0, 1) == 1);
          cur_addr[p]  = {8'((p == 1) ? $urandom_range(128, 255) : $urandom_range(0, 127)), 2'b00};
          cur_wdata[p] = $urandom;
          applyStimulus(p == 1, cur_we[p], cur_addr[p], cur_wdata[p]);
          busy[p] = 1'b1;
          wait_cyc[p] = 0;
          started[p] = 1'b1;
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (started[p]) contended[p] = busy[1 - p];
      end
    end
    checkOutput("rnd_drained", 64'(busy[0] | busy[1]), 64'(0));
    checkOutput("rnd_c_cnt", 64'(c_cnt), 64'(exp_c));
    checkOutput("rnd_d_cnt", 64'(d_cnt), 64'(exp_d));

    // Reset dropped during GNT_D: no ack, counters cleared, re-request works.
    applyStimulus(1'b1, 1'b0, 10'h100, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_d_ack", 64'(d_ack), 64'(0));
    checkOutput("mid_rst_dm_we", 64'(dm_we), 64'(0));
    checkOutput("mid_rst_c_cnt", 64'(c_cnt), 64'(0));
    checkOutput("mid_rst_d_cnt", 64'(d_cnt), 64'(0));
    @(negedge clk);
    checkOutput("mid_rst_no_ack", 64'(d_ack), 64'(0));
    release_port(1'b1);
    @(negedge clk);
    rst = 1'b1;
    exp_c = 0; exp_d = 0;
    @(negedge clk);
    checkOutput("post_rst_no_ack", 64'(d_ack), 64'(0));
    applyStimulus(1'b1, 1'b0, 10'h100, 32'h0);
    wait_ack(1'b1, 6, cyc_cnt);
    checkOutput("post_rst_latency", 64'(cyc_cnt), 64'(2));
    checkOutput("post_rst_rdata", 64'(d_rdata), 64'(mem[64]));
    release_port(1'b1); exp_d++;
    @(negedge clk);
    checkOutput("post_rst_d_cnt", 64'(d_cnt), 64'(exp_d));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
